// File: rtl/ray_pkg.sv
// Shared fixed-point types, FSM encoding and saturation helpers for the
// ray/sphere intersect units.
package ray_pkg;

    localparam int FX_W    = 16;
    localparam int FX_FRAC = 8;

    typedef logic signed [FX_W-1:0] fx_t;

    localparam fx_t T_MAX = fx_t'((1 << (FX_W - 1)) - 1);

    typedef enum logic [2:0] {IDLE, SUB, DOT, DISC, SQRT, SEL, DONE} state_e;

    // Clamp a signed value into the unsigned range [0, 2^w-1].
    function automatic logic [63:0] sat_u(input logic signed [127:0] v, input int unsigned w);
        logic signed [127:0] lim;
        lim = (128'sd1 <<< w) - 128'sd1;
        if (v < 0)
            return '0;
        if (v > lim)
            return 64'(lim);
        return 64'(v);
    endfunction

    // Clamp a non-negative t to the largest positive w-bit value.
    function automatic logic [63:0] sat_t(input logic signed [63:0] v, input int unsigned w);
        logic signed [63:0] lim;
        lim = (64'sd1 <<< (w - 1)) - 64'sd1;
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/fixed_sqrt_iter.sv
// Restoring bit-serial integer square root: one result bit per cycle,
// WIDTH cycles after start; done is high during the final iteration cycle.
module fixed_sqrt_iter #(
    parameter int WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [2*WIDTH-1:0] radicand,
    output logic               done,
    output logic [WIDTH-1:0]   root
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] rad_q;
    logic [WIDTH+1:0]   rem_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic [WIDTH+3:0]   trial_rem, trial;
    logic               ge;

    always_comb begin
        trial_rem = {rem_q, rad_q[2*WIDTH-1 -: 2]};
        trial     = {2'b00, root, 2'b01};
        ge        = (trial_rem >= trial);
    end

    assign done = busy_q && (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            rad_q  <= radicand;
            rem_q  <= '0;
            root   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rad_q  <= rad_q << 2;
            rem_q  <= ge ? (WIDTH+2)'(trial_rem - trial) : trial_rem[WIDTH+1:0];
            root   <= {root[WIDTH-2:0], ge};
            cnt_q  <= cnt_q + 1'b1;
            busy_q <= !done;
        end
    end

endmodule

// File: rtl/ray_sphere_closest_hit.sv
// Tests one ray against every enabled slot of a small sphere table with a
// single shared datapath, returning the nearest non-negative hit.
module ray_sphere_closest_hit
    import ray_pkg::*;
#(
    parameter int W           = 16,
    parameter int FRAC        = 8,
    parameter int NUM_SPHERES = 4,
    parameter int IDW         = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] ray_origin_x,
    input  logic signed [W-1:0] ray_origin_y,
    input  logic signed [W-1:0] ray_origin_z,
    input  logic signed [W-1:0] ray_dir_x,
    input  logic signed [W-1:0] ray_dir_y,
    input  logic signed [W-1:0] ray_dir_z,
    input  logic                scene_we,
    input  logic [IDW-1:0]      scene_addr,
    input  logic signed [W-1:0] scene_center_x,
    input  logic signed [W-1:0] scene_center_y,
    input  logic signed [W-1:0] scene_center_z,
    input  logic [W-1:0]        scene_radius,
    input  logic                scene_enable,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_hit,
    output logic [W-1:0]        out_t,
    output logic [IDW-1:0]      out_id
);

    localparam int AW = 2*W + 4;
    localparam int DW = 2*AW;
    localparam logic [W-1:0] TMAX_W = {1'b0, {(W-1){1'b1}}};

    state_e state, state_n;

    logic signed [W-1:0]  cen_x [NUM_SPHERES];
    logic signed [W-1:0]  cen_y [NUM_SPHERES];
    logic signed [W-1:0]  cen_z [NUM_SPHERES];
    logic [W-1:0]         rad   [NUM_SPHERES];
    logic [NUM_SPHERES-1:0] en;

    logic signed [W-1:0]  org_x, org_y, org_z, dir_x, dir_y, dir_z;
    logic signed [W:0]    oc_x, oc_y, oc_z;
    logic signed [AW-1:0] b_acc, cc_acc, b_nxt, cc_nxt, rr, bq;
    logic signed [DW-1:0] disc;
    logic [2*W-1:0]       rad_in;
    logic signed [W+1:0]  bq_t, s_t, t0, t1, t_sel;
    logic                 has_t;
    logic [W-1:0]         t_sat, sq_root, best_t;
    logic [IDW-1:0]       slot, best_id;
    logic                 best_hit, adv, last_slot, sq_start, sq_done, wr_ok;

    assign wr_ok     = scene_we && (state == IDLE) && (32'(scene_addr) < NUM_SPHERES);
    assign last_slot = (slot == IDW'(NUM_SPHERES - 1));

    always_comb begin
        rr     = signed'(AW'(rad[slot])) * signed'(AW'(rad[slot]));
        b_nxt  = AW'(oc_x) * AW'(dir_x) + AW'(oc_y) * AW'(dir_y) + AW'(oc_z) * AW'(dir_z);
        cc_nxt = AW'(oc_x) * AW'(oc_x) + AW'(oc_y) * AW'(oc_y) + AW'(oc_z) * AW'(oc_z) - rr;
        // b is rescaled to FRAC fraction bits so its square lines up with cc
        bq     = b_acc >>> FRAC;
        disc   = DW'(bq) * DW'(bq) - DW'(cc_acc);
        rad_in = (2*W)'(sat_u(128'(disc), 2*W));
        bq_t   = (W+2)'(bq);
        s_t    = signed'((W+2)'(sq_root));
        t0     = -bq_t - s_t;
        t1     = -bq_t + s_t;
        has_t  = 1'b1;
        t_sel  = t0;
        if (t0 < 0) begin
            t_sel = t1;
            has_t = (t1 >= 0);
        end
        t_sat  = W'(sat_t(64'(t_sel), W));
    end

    always_comb begin
        state_n  = state;
        adv      = 1'b0;
        sq_start = 1'b0;
        case (state)
            IDLE: if (in_valid) state_n = SUB;
            SUB:  if (!en[slot]) adv = 1'b1; else state_n = DOT;
            DOT:  state_n = DISC;
            DISC: if (disc < 0) adv = 1'b1;
                  else begin state_n = SQRT; sq_start = 1'b1; end
            SQRT: if (sq_done) state_n = SEL;
            SEL:  adv = 1'b1;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (adv) state_n = last_slot ? DONE : SUB;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SPHERES; i++) begin
                cen_x[i] <= '0;
                cen_y[i] <= '0;
                cen_z[i] <= '0;
                rad[i]   <= '0;
            end
            en <= '0;
        end else if (wr_ok) begin
            cen_x[scene_addr] <= scene_center_x;
            cen_y[scene_addr] <= scene_center_y;
            cen_z[scene_addr] <= scene_center_z;
            rad[scene_addr]   <= scene_radius;
            en[scene_addr]    <= scene_enable;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            {org_x, org_y, org_z, dir_x, dir_y, dir_z} <= '0;
            {oc_x, oc_y, oc_z} <= '0;
            b_acc    <= '0;
            cc_acc   <= '0;
            slot     <= '0;
            best_t   <= '0;
            best_hit <= 1'b0;
            best_id  <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    {org_x, org_y, org_z} <= {ray_origin_x, ray_origin_y, ray_origin_z};
                    {dir_x, dir_y, dir_z} <= {ray_dir_x, ray_dir_y, ray_dir_z};
                    slot     <= '0;
                    best_t   <= TMAX_W;
                    best_hit <= 1'b0;
                    best_id  <= '0;
                end
                SUB: begin
                    oc_x <= (W+1)'(org_x) - (W+1)'(cen_x[slot]);
                    oc_y <= (W+1)'(org_y) - (W+1)'(cen_y[slot]);
                    oc_z <= (W+1)'(org_z) - (W+1)'(cen_z[slot]);
                end
                DOT: begin
                    b_acc  <= b_nxt;
                    cc_acc <= cc_nxt;
                end
                // strict compare keeps the lower index on equal t
                SEL: if (has_t && (t_sat < best_t)) begin
                    best_t   <= t_sat;
                    best_hit <= 1'b1;
                    best_id  <= slot;
                end
                default: ;
            endcase
            if (adv) slot <= slot + 1'b1;
        end
    end

    fixed_sqrt_iter #(.WIDTH(W)) u_sqrt (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (sq_start),
        .radicand (rad_in),
        .done     (sq_done),
        .root     (sq_root)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_hit   = best_hit;
    assign out_t     = best_t;
    assign out_id    = best_id;

endmodule

// File: tb/tb_ray_sphere_closest_hit.sv
// Bench for ray_sphere_closest_hit: directed scenes plus random rays checked
// against a plain-arithmetic closest-hit model.
module tb_ray_sphere_closest_hit;

    localparam int W   = 16;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic in_valid = 1'b0, in_ready;
    logic signed [W-1:0] ray_origin_x = '0, ray_origin_y = '0, ray_origin_z = '0;
    logic signed [W-1:0] ray_dir_x = '0, ray_dir_y = '0, ray_dir_z = '0;
    logic scene_we = 1'b0;
    logic [IDW-1:0] scene_addr = '0;
    logic signed [W-1:0] scene_center_x = '0, scene_center_y = '0, scene_center_z = '0;
    logic [W-1:0] scene_radius = '0;
    logic scene_enable = 1'b0;
    logic out_valid, out_ready = 1'b0, out_hit;
    logic [W-1:0] out_t;
    logic [IDW-1:0] out_id;

    always #5 clock = ~clock;

    ray_sphere_closest_hit #(.W(W), .FRAC(8), .NUM_SPHERES(N)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .ray_origin_x(ray_origin_x), .ray_origin_y(ray_origin_y), .ray_origin_z(ray_origin_z),
        .ray_dir_x(ray_dir_x), .ray_dir_y(ray_dir_y), .ray_dir_z(ray_dir_z),
        .scene_we(scene_we), .scene_addr(scene_addr),
        .scene_center_x(scene_center_x), .scene_center_y(scene_center_y),
        .scene_center_z(scene_center_z), .scene_radius(scene_radius),
        .scene_enable(scene_enable),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_hit(out_hit), .out_t(out_t), .out_id(out_id)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_vec = 0, n_bad = 0;
    int m_cx[N], m_cy[N], m_cz[N], m_r[N];
    bit m_en[N];
    bit exp_hit;
    int exp_t, exp_id, exp_lat, acc_cyc;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint isqrt(input longint d);
        longint s;
        s = longint'($sqrt(real'(d)));
        while (s * s > d) s--;
        while ((s + 1) * (s + 1) <= d) s++;
        return s;
    endfunction

    // Geometric closest hit, with the per-slot cycle costs summed as latency.
    function automatic void model(input longint ox, oy, oz, dx, dy, dz,
                                  output bit hit, output int t, output int id, output int lat);
        longint best;
        best = 32767; hit = 0; id = 0; lat = 0;
        for (int i = 0; i < N; i++) begin
            longint ocx, ocy, ocz, b, cc, bq, disc, s, tt;
            if (!m_en[i]) begin lat += 1; continue; end
            ocx = ox - m_cx[i]; ocy = oy - m_cy[i]; ocz = oz - m_cz[i];
            b    = ocx * dx + ocy * dy + ocz * dz;
            cc   = ocx * ocx + ocy * ocy + ocz * ocz - longint'(m_r[i]) * m_r[i];
            bq   = b >>> 8;
            disc = bq * bq - cc;
            if (disc < 0) begin lat += 3; continue; end
            lat += W + 4;
            s = isqrt(disc);
            if (-bq - s >= 0)      tt = -bq - s;
            else if (-bq + s >= 0) tt = -bq + s;
            else continue;
            if (tt > 32767) tt = 32767;
            if (tt < best) begin best = tt; hit = 1; id = i; end
        end
        t = int'(best);
    endfunction

    task automatic set_slot(input int a, cx, cy, cz, r, input bit e);
        @(negedge clock);
        scene_we = 1'b1; scene_addr = IDW'(a);
        scene_center_x = W'(cx); scene_center_y = W'(cy); scene_center_z = W'(cz);
        scene_radius = W'(r); scene_enable = e;
        @(posedge clock); #1;
        scene_we = 1'b0;
        m_cx[a] = cx; m_cy[a] = cy; m_cz[a] = cz; m_r[a] = r; m_en[a] = e;
    endtask

    task automatic pin(input string nm, input int ox, oy, oz, dx, dy, dz,
                       input bit h, input int t, input int id, input int lat);
        bit mh; int mt, mid, ml;
        model(ox, oy, oz, dx, dy, dz, mh, mt, mid, ml);
        chk({nm, "_model_hit"}, mh, h);
        chk({nm, "_model_t"}, mt, t);
        chk({nm, "_model_id"}, mid, id);
        chk({nm, "_model_lat"}, ml, lat);
    endtask

    task automatic run_ray(input int ox, oy, oz, dx, dy, dz, input int hold);
        bit h; int t, id, lat, n;
        model(ox, oy, oz, dx, dy, dz, h, t, id, lat);
        exp_hit = h; exp_t = t; exp_id = id; exp_lat = lat;
        @(negedge clock);
        chk("in_ready_idle", in_ready, 1);
        ray_origin_x = W'(ox); ray_origin_y = W'(oy); ray_origin_z = W'(oz);
        ray_dir_x = W'(dx); ray_dir_y = W'(dy); ray_dir_z = W'(dz);
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        acc_cyc = cyc;
        n = 0;
        while (!out_valid && n < 400) begin @(posedge clock); #1; n++; end
        if (!out_valid) begin
            n_vec++; n_bad++;
            $display("FAIL out_valid_timeout: no result after %0d cycles, expected latency %0d", n, lat);
        end
        if (hold > 0) begin
            // a scene write while the result is held must not land
            scene_we = 1'b1; scene_addr = '0;
            scene_center_x = '0; scene_center_y = '0; scene_center_z = '0;
            scene_radius = 16'h0800; scene_enable = 1'b1;
            repeat (hold) @(posedge clock);
            #1 scene_we = 1'b0;
        end
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    // Compare process: every cycle a result is presented it must match the model.
    bit seen_valid = 0;
    always @(negedge clock) begin
        if (!reset_n) seen_valid = 0;
        else if (out_valid) begin
            chk("out_hit", out_hit, exp_hit);
            chk("out_t", out_t, exp_t);
            chk("out_id", out_id, exp_id);
            chk("in_ready_busy", in_ready, 0);
            if (!seen_valid) chk("latency", cyc - acc_cyc, exp_lat);
            seen_valid = 1;
        end else seen_valid = 0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            m_cx[i] = 0; m_cy[i] = 0; m_cz[i] = 0; m_r[i] = 0; m_en[i] = 0;
        end
        repeat (2) @(negedge clock);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_hit", out_hit, 0);
        chk("rst_out_t", out_t, 0);
        chk("rst_out_id", out_id, 0);
        reset_n = 1'b1;

        set_slot(0, 0, 0, 'h0A00, 'h0200, 1);
        pin("single", 0, 0, 0, 0, 0, 'h100, 1, 'h0800, 0, 23);
        run_ray(0, 0, 0, 0, 0, 'h100, 0);

        set_slot(1, 0, 0, 'h0500, 'h0100, 1);
        pin("nearer", 0, 0, 0, 0, 0, 'h100, 1, 'h0400, 1, 42);
        run_ray(0, 0, 0, 0, 0, 'h100, 0);

        set_slot(1, 0, 0, 0, 0, 0);
        pin("behind", 0, 0, 0, 0, 0, -'sh100, 0, 'h7FFF, 0, 23);
        run_ray(0, 0, 0, 0, 0, -'sh100, 0);

        set_slot(0, 0, 0, 0, 'h0300, 1);
        pin("inside", 0, 0, 0, 'h100, 0, 0, 1, 'h0300, 0, 23);
        run_ray(0, 0, 0, 'h100, 0, 0, 0);

        set_slot(0, 0, 'h0200, 'h0A00, 'h0200, 1);
        pin("tangent", 0, 0, 0, 0, 0, 'h100, 1, 'h0A00, 0, 23);
        run_ray(0, 0, 0, 0, 0, 'h100, 0);

        set_slot(0, 0, 0, 'h0200, 'h0200, 1);
        pin("t_zero", 0, 0, 0, 0, 0, 'h100, 1, 0, 0, 23);
        run_ray(0, 0, 0, 0, 0, 'h100, 0);

        set_slot(0, 0, 0, 0, 0, 0);
        set_slot(2, 0, 0, 'h0A00, 'h0200, 1);
        set_slot(3, 0, 0, 'h0A00, 'h0200, 1);
        pin("tie", 0, 0, 0, 0, 0, 'h100, 1, 'h0800, 2, 42);
        run_ray(0, 0, 0, 0, 0, 'h100, 10);
        run_ray(0, 0, 0, 0, 0, 'h100, 0);

        for (int k = 0; k < 30; k++) begin
            for (int s = 0; s < N; s++)
                set_slot(s, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
                         int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 1023)),
                         bit'($urandom_range(0, 1)));
            run_ray(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
                    int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 512)) - 256,
                    int'($urandom_range(0, 512)) - 256, int'($urandom_range(0, 512)) - 256,
                    int'($urandom_range(0, 2)));
        end

        // reset while slot 0 is in the square-root phase
        set_slot(0, 0, 0, 'h0A00, 'h0200, 1);
        @(negedge clock);
        ray_origin_x = '0; ray_origin_y = '0; ray_origin_z = '0;
        ray_dir_x = '0; ray_dir_y = '0; ray_dir_z = 16'h0100;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_t", out_t, 0);
        chk("midrst_out_hit", out_hit, 0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            m_cx[i] = 0; m_cy[i] = 0; m_cz[i] = 0; m_r[i] = 0; m_en[i] = 0;
        end
        pin("cleared", 0, 0, 0, 0, 0, 'h100, 0, 'h7FFF, 0, 4);
        run_ray(0, 0, 0, 0, 0, 'h100, 0);

        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
